// File: rtl/instr_encoder_if.sv
// Program-load bus for instr_encoder: field-set input handshake plus
// instruction-memory write port and load status.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              fmt;
    logic [5:0]        opcode;
    logic [4:0]        rdst;
    logic [4:0]        rsrc1;
    logic [4:0]        rsrc2;
    logic [15:0]       imm;
    logic [6:0]        functR;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err;

    modport master (
        output start, base_addr, in_valid, in_last, fmt,
               opcode, rdst, rsrc1, rsrc2, imm, functR,
        input  in_ready, im_we, im_addr, im_wdata, busy, done, count, err
    );

    modport slave (
        input  start, base_addr, in_valid, in_last, fmt,
               opcode, rdst, rsrc1, rsrc2, imm, functR,
        output in_ready, im_we, im_addr, im_wdata, busy, done, count, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs R/I-type field sets into 32-bit IR words and streams them into
// instruction memory. Define ENC_CHECK_EN to enable the sticky err check.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       word_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   count_d;
    logic              accept;
    logic              full;

    always_comb begin
        word_d = '0;
        word_d[31:26] = bus.opcode;
        word_d[25:21] = bus.rdst;
        word_d[20:16] = bus.rsrc1;
        if (bus.fmt) begin
            word_d[15:0] = bus.imm;
        end else begin
            word_d[15:11] = bus.rsrc2;
            word_d[10:7]  = '0;
            word_d[6:0]   = bus.functR;
        end
    end

    // in_ready_q is only ever high in LOAD, so it doubles as the state gate.
    assign accept  = in_ready_q & bus.in_valid;
    assign addr_d  = addr_q + ADDR_W'(1);
    assign count_d = count_q + (ADDR_W + 1)'(1);
    assign full    = count_d[ADDR_W];

`ifdef ENC_CHECK_EN
    logic err_q;
    logic bad;

    assign bad = bus.fmt ? (bus.opcode == '0) : (bus.rdst == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            err_q <= 1'b0;
        end else if (accept && bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q     <= bus.base_addr;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        we_q    <= 1'b1;
                        waddr_q <= addr_q;
                        wdata_q <= word_d;
                        addr_q  <= addr_d;
                        count_q <= count_d;
                        // done rises together with the final write strobe.
                        if (bus.in_last || full) begin
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = we_q;
    assign bus.im_addr  = waddr_q;
    assign bus.im_wdata = wdata_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with a write scoreboard.
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int unsigned AW = 8;

    typedef struct {
        logic        fmt;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
        logic [6:0]  fn;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [AW-1:0] exp_addr;
    int            exp_count;
    wr_t           sbq[$];
    vec_t          vt[5];

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] enc_model(input vec_t v);
        if (v.fmt) return {v.op, v.rd, v.rs1, v.imm};
        return {v.op, v.rd, v.rs1, v.rs2, 4'b0000, v.fn};
    endfunction

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_t w;
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         bus.im_addr, bus.im_wdata);
            end else begin
                w = sbq.pop_front();
                chk("im_addr", 32'(bus.im_addr), 32'(w.a));
                chk("im_wdata", bus.im_wdata, w.d);
            end
        end
    end

    task automatic drive(input vec_t v, input logic last);
        bus.fmt    = v.fmt;
        bus.opcode = v.op;
        bus.rdst   = v.rd;
        bus.rsrc1  = v.rs1;
        bus.rsrc2  = v.rs2;
        bus.imm    = v.imm;
        bus.functR = v.fn;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        exp_addr  = base;
        exp_count = 0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("load_in_ready", 32'(bus.in_ready), 32'd1);
        chk("load_busy", 32'(bus.busy), 32'd1);
        chk("start_count", 32'(bus.count), 32'd0);
    endtask

    task automatic send(input vec_t v, input logic last);
        wr_t w;
        drive(v, last);
        chk("send_in_ready", 32'(bus.in_ready), 32'd1);
        w.a = exp_addr;
        w.d = v.exp;
        sbq.push_back(w);
        exp_addr = exp_addr + 1'b1;
        exp_count++;
        @(negedge clk);
    endtask

    task automatic finish_check();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("final_count", 32'(bus.count), 32'(exp_count));
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("done_cleared", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        chk("idle_we", 32'(bus.im_we), 32'd0);
        chk("count_hold", 32'(bus.count), 32'(exp_count));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
        chk({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
        chk({tag, "_im_wdata"}, bus.im_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish within 100us");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vt[0] = '{1'b0, 6'h00, 5'd3,  5'd1,  5'd2,  16'h0000, 7'h20, 32'h00611020};
        vt[1] = '{1'b1, 6'h08, 5'd4,  5'd5,  5'd0,  16'hFFFF, 7'h00, 32'h2085FFFF};
        vt[2] = '{1'b0, 6'h3F, 5'd31, 5'd31, 5'd31, 16'hFFFF, 7'h7F, 32'hFFFFF87F};
        vt[3] = '{1'b1, 6'h23, 5'd2,  5'd29, 5'd31, 16'h1234, 7'h7F, 32'h8C5D1234};
        vt[4] = '{1'b0, 6'h01, 5'd0,  5'd0,  5'd0,  16'h0000, 7'h00, 32'h04000000};

        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.fmt = 1'b0; bus.opcode = '0; bus.rdst = '0; bus.rsrc1 = '0;
        bus.rsrc2 = '0; bus.imm = '0; bus.functR = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single R-type program at 0x10, with field set presented alongside start.
        bus.start = 1'b1;
        bus.base_addr = 8'h10;
        drive(vt[2], 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        chk("start_no_accept_we", 32'(bus.im_we), 32'd0);
        chk("start_no_accept_count", 32'(bus.count), 32'd0);
        chk("start_in_ready", 32'(bus.in_ready), 32'd1);
        exp_addr = 8'h10;
        exp_count = 0;
        send(vt[0], 1'b1);
        finish_check();

        // Three words wrapping the address space.
        do_start(8'hFE);
        for (int i = 1; i <= 3; i++) send(vt[i], (i == 3));
        finish_check();
        chk("wrap_sb_drained", 32'(sbq.size()), 32'd0);

        // Encoding-check vector: R-type with rdst=0 is still written.
        do_start(8'h80);
        send(vt[4], 1'b1);
        finish_check();
`ifdef ENC_CHECK_EN
        chk("err_set", 32'(bus.err), 32'd1);
`else
        chk("err_tied", 32'(bus.err), 32'd0);
`endif
        do_start(8'h90);
        chk("err_cleared", 32'(bus.err), 32'd0);
        send(vt[1], 1'b1);
        finish_check();

        // Fill the whole memory without in_last; in_valid stays high afterwards.
        do_start(8'h00);
        for (int i = 0; i < 256; i++) begin
            v.fmt = i[0];
            v.op  = 6'(i + 1);
            v.rd  = 5'(i);
            v.rs1 = 5'(i >> 3);
            v.rs2 = 5'(~i);
            v.imm = 16'(i * 257);
            v.fn  = 7'(i ^ 7'h55);
            v.exp = enc_model(v);
            send(v, 1'b0);
        end
        chk("full_done", 32'(bus.done), 32'd1);
        chk("full_count", 32'(bus.count), 32'd256);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("full_no_more_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        chk("full_count_hold", 32'(bus.count), 32'd256);

        // Reset the cycle after the second accept while a third is offered.
        do_start(8'h40);
        send(vt[1], 1'b0);
        send(vt[2], 1'b0);
        rst = 1'b1;
        drive(vt[3], 1'b0);
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_we", 32'(bus.im_we), 32'd0);
        chk("post_rst_idle", 32'(bus.in_ready), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
